// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: steers the PC register, handshakes with instruction memory,
// buffers the fetched word for IF/ID and resolves EXE redirects. Optional counters: FETCH_PERF_EN.
module fetch_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PC_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_address,
    output logic              freeze,
    output logic              imem_req,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              hazard_stall,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic              flush_if
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       wait_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_t              state_q, state_d;
    logic                inst_valid_q, inst_valid_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic                pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0]   seq_addr;

    assign seq_addr   = pc + STEP;
    assign imem_req   = (state_q == REQ);
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;

    // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its peers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        next_address = seq_addr;
        freeze       = 1'b1;
        flush_if     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Redirects are ignored here: EXE holds nothing yet.
                if (!hazard_stall) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                if (imem_ready) begin
                    if (branch_taken || pend_valid_q) begin
                        // A fresh branch is younger than any parked one, so it wins.
                        next_address = branch_taken ? branch_addr : pend_addr_q;
                        freeze       = 1'b0;
                        flush_if     = 1'b1;
                        inst_valid_d = 1'b0;
                        pend_valid_d = 1'b0;
                        pend_addr_d  = '0;
                    end else begin
                        inst_d       = imem_rdata;
                        inst_valid_d = 1'b1;
                        if (hazard_stall) begin
                            state_d = HOLD;
                        end else begin
                            freeze = 1'b0;
                        end
                    end
                end else begin
                    inst_valid_d = 1'b0;
                    if (branch_taken) begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = branch_addr;
                    end
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    next_address = branch_addr;
                    freeze       = 1'b0;
                    flush_if     = 1'b1;
                    inst_valid_d = 1'b0;
                    pend_valid_d = 1'b0;
                    pend_addr_d  = '0;
                    state_d      = REQ;
                end else if (!hazard_stall) begin
                    freeze  = 1'b0;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef FETCH_PERF_EN
    logic advance;
    logic wait_cycle;

    // An advance is any cycle the PC moves without a redirect.
    assign advance    = !freeze && !flush_if;
    assign wait_cycle = (state_q == REQ) && !imem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
            wait_count  <= '0;
        end else begin
            if (advance) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (wait_cycle) begin
                wait_count <= wait_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: hand-derived vector table for the directed scenarios,
// then randomized traffic compared against a transaction-level reference model.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] next_address;
    logic        freeze;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        hazard_stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic        flush_if;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] wait_count;
`endif

    fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .PC_STEP(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .next_address (next_address),
        .freeze       (freeze),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .hazard_stall (hazard_stall),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .flush_if     (flush_if)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count  (fetch_count),
        .wait_count   (wait_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: a fetch is either outstanding, parked behind a stall, or not started.
    // Redirects seen while waiting are kept in a queue holding at most the youngest one.
    logic        m_fetching, m_parked, m_valid;
    logic [31:0] m_inst;
    logic [31:0] pend_q[$];

    logic        e_req, e_freeze, e_flush, e_valid;
    logic [31:0] e_next, e_inst;
    logic        n_fetching, n_parked, n_valid, n_pend_clear, n_pend_set;
    logic [31:0] n_inst, n_pend_addr;

    task automatic model_reset();
        m_fetching = 1'b0;
        m_parked   = 1'b0;
        m_valid    = 1'b0;
        m_inst     = 32'h0;
        pend_q.delete();
    endtask

    task automatic model_eval(input logic rdy, input logic [31:0] rdata, input logic br,
                              input logic [31:0] baddr, input logic stall, input logic [31:0] pc_in);
        e_req   = m_fetching;
        e_next  = pc_in + 32'd4;
        e_freeze = 1'b1;
        e_flush = 1'b0;
        e_valid = m_valid;
        e_inst  = m_inst;
        n_fetching = m_fetching;
        n_parked   = m_parked;
        n_valid    = m_valid;
        n_inst     = m_inst;
        n_pend_clear = 1'b0;
        n_pend_set   = 1'b0;
        n_pend_addr  = 32'h0;
        if (m_fetching) begin
            if (rdy && (br || pend_q.size() != 0)) begin
                e_next = br ? baddr : pend_q[0];
                e_freeze = 1'b0;
                e_flush = 1'b1;
                n_valid = 1'b0;
                n_pend_clear = 1'b1;
            end else if (rdy) begin
                n_inst  = rdata;
                n_valid = 1'b1;
                if (stall) begin
                    n_fetching = 1'b0;
                    n_parked   = 1'b1;
                end else begin
                    e_freeze = 1'b0;
                end
            end else begin
                n_valid = 1'b0;
                if (br) begin
                    n_pend_set  = 1'b1;
                    n_pend_addr = baddr;
                end
            end
        end else if (m_parked) begin
            if (br) begin
                e_next = baddr;
                e_freeze = 1'b0;
                e_flush = 1'b1;
                n_valid = 1'b0;
                n_parked = 1'b0;
                n_fetching = 1'b1;
                n_pend_clear = 1'b1;
            end else if (!stall) begin
                e_freeze = 1'b0;
                n_parked = 1'b0;
                n_fetching = 1'b1;
            end
        end else if (!stall) begin
            n_fetching = 1'b1;
        end
    endtask

    task automatic model_commit();
        m_fetching = n_fetching;
        m_parked   = n_parked;
        m_valid    = n_valid;
        m_inst     = n_inst;
        if (n_pend_clear) pend_q.delete();
        if (n_pend_set) begin
            pend_q.delete();
            pend_q.push_back(n_pend_addr);
        end
    endtask

    typedef struct {
        logic        ready;
        logic [31:0] rdata;
        logic        br;
        logic [31:0] baddr;
        logic        stall;
        logic [31:0] pc;
        logic        e_req;
        logic        e_freeze;
        logic        e_flush;
        logic [31:0] e_next;
        logic        e_valid;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rdy, input logic [31:0] rdata, input logic br, input logic [31:0] baddr,
                       input logic stall, input logic [31:0] pc_in, input logic x_req, input logic x_freeze,
                       input logic x_flush, input logic [31:0] x_next, input logic x_valid, input logic [31:0] x_inst);
        vec_t v;
        v.ready = rdy; v.rdata = rdata; v.br = br; v.baddr = baddr; v.stall = stall; v.pc = pc_in;
        v.e_req = x_req; v.e_freeze = x_freeze; v.e_flush = x_flush;
        v.e_next = x_next; v.e_valid = x_valid; v.e_inst = x_inst;
        tbl.push_back(v);
    endtask

    // Entered just after a rising edge; samples on the falling edge; returns just after the next rising edge.
    task automatic run_vec(input int idx, input vec_t v);
        imem_ready = v.ready; imem_rdata = v.rdata; branch_taken = v.br;
        branch_addr = v.baddr; hazard_stall = v.stall; pc = v.pc;
        model_eval(v.ready, v.rdata, v.br, v.baddr, v.stall, v.pc);
        @(negedge clk);
        check($sformatf("v%0d.imem_req", idx), 32'(imem_req), 32'(v.e_req));
        check($sformatf("v%0d.freeze", idx), 32'(freeze), 32'(v.e_freeze));
        check($sformatf("v%0d.flush_if", idx), 32'(flush_if), 32'(v.e_flush));
        check($sformatf("v%0d.next_address", idx), next_address, v.e_next);
        check($sformatf("v%0d.inst_valid", idx), 32'(inst_valid), 32'(v.e_valid));
        check($sformatf("v%0d.inst", idx), inst, v.e_inst);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    localparam int RST_IDX = 31;

    initial begin
        logic [31:0] pc_reg;
`ifdef FETCH_PERF_EN
        logic [31:0] f0, w0;
        f0 = 32'h0;
        w0 = 32'h0;
`endif
        reset = 1'b0; pc = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
        branch_taken = 1'b0; branch_addr = 32'h0; hazard_stall = 1'b0;
        model_reset();

        //   rdy rdata          br baddr   stl pc            req frz fl next          vld inst
        add(1, 32'hA0A0A0A0, 1, 32'hABC, 0, 32'h0,        0, 1, 0, 32'h4,        0, 32'h0);        // 0 IDLE
        add(1, 32'h11110000, 0, 32'h0,   0, 32'h0,        1, 0, 0, 32'h4,        0, 32'h0);        // 1
        add(1, 32'h11110004, 0, 32'h0,   0, 32'h4,        1, 0, 0, 32'h8,        1, 32'h11110000);
        add(1, 32'h11110008, 0, 32'h0,   0, 32'h8,        1, 0, 0, 32'hC,        1, 32'h11110004);
        add(0, 32'h0,        0, 32'h0,   0, 32'hC,        1, 1, 0, 32'h10,       1, 32'h11110008); // 4 slow
        add(0, 32'h0,        0, 32'h0,   0, 32'hC,        1, 1, 0, 32'h10,       0, 32'h11110008);
        add(1, 32'h2222000C, 0, 32'h0,   0, 32'hC,        1, 0, 0, 32'h10,       0, 32'h11110008);
        add(0, 32'h0,        0, 32'h0,   0, 32'h10,       1, 1, 0, 32'h14,       1, 32'h2222000C);
        add(0, 32'h0,        0, 32'h0,   0, 32'h10,       1, 1, 0, 32'h14,       0, 32'h2222000C);
        add(1, 32'h22220010, 0, 32'h0,   0, 32'h10,       1, 0, 0, 32'h14,       0, 32'h2222000C); // 9
        add(0, 32'h0,        1, 32'h100, 0, 32'h14,       1, 1, 0, 32'h18,       1, 32'h22220010); // 10 pend
        add(0, 32'h0,        0, 32'h0,   0, 32'h14,       1, 1, 0, 32'h18,       0, 32'h22220010);
        add(1, 32'h33333333, 0, 32'h0,   0, 32'h14,       1, 0, 1, 32'h100,      0, 32'h22220010);
        add(0, 32'h0,        0, 32'h0,   0, 32'h100,      1, 1, 0, 32'h104,      0, 32'h22220010);
        add(1, 32'hDEADBEEF, 0, 32'h0,   1, 32'h100,      1, 1, 0, 32'h104,      0, 32'h22220010); // 14 stall
        add(0, 32'h0,        0, 32'h0,   1, 32'h100,      0, 1, 0, 32'h104,      1, 32'hDEADBEEF);
        add(1, 32'h55555555, 0, 32'h0,   1, 32'h100,      0, 1, 0, 32'h104,      1, 32'hDEADBEEF);
        add(0, 32'h0,        0, 32'h0,   0, 32'h100,      0, 0, 0, 32'h104,      1, 32'hDEADBEEF);
        add(0, 32'h0,        0, 32'h0,   0, 32'h104,      1, 1, 0, 32'h108,      1, 32'hDEADBEEF);
        add(1, 32'h44444444, 0, 32'h0,   0, 32'hFFFFFFFC, 1, 0, 0, 32'h0,        0, 32'hDEADBEEF); // 19 wrap
        add(0, 32'h0,        0, 32'h0,   0, 32'h0,        1, 1, 0, 32'h4,        1, 32'h44444444);
        add(0, 32'h0,        1, 32'h200, 0, 32'h0,        1, 1, 0, 32'h4,        0, 32'h44444444); // 21
        add(0, 32'h0,        1, 32'h300, 0, 32'h0,        1, 1, 0, 32'h4,        0, 32'h44444444);
        add(1, 32'h12345678, 0, 32'h0,   0, 32'h0,        1, 0, 1, 32'h300,      0, 32'h44444444);
        add(0, 32'h0,        1, 32'h500, 0, 32'h300,      1, 1, 0, 32'h304,      0, 32'h44444444);
        add(1, 32'h12345678, 1, 32'h600, 0, 32'h300,      1, 0, 1, 32'h600,      0, 32'h44444444); // 25
        add(1, 32'h66666666, 0, 32'h0,   0, 32'h600,      1, 0, 0, 32'h604,      0, 32'h44444444);
        add(1, 32'h77777777, 0, 32'h0,   1, 32'h604,      1, 1, 0, 32'h608,      1, 32'h66666666);
        add(0, 32'h0,        1, 32'h800, 1, 32'h604,      0, 0, 1, 32'h800,      1, 32'h77777777); // 28
        add(0, 32'h0,        0, 32'h0,   0, 32'h800,      1, 1, 0, 32'h804,      0, 32'h77777777);
        add(0, 32'h0,        1, 32'h900, 0, 32'h800,      1, 1, 0, 32'h804,      0, 32'h77777777); // 30
        add(1, 32'h88888888, 0, 32'h0,   0, 32'h800,      0, 1, 0, 32'h804,      0, 32'h0);        // 31 IDLE
        add(1, 32'h88888888, 0, 32'h0,   0, 32'h800,      1, 0, 0, 32'h804,      0, 32'h0);
        add(1, 32'h99999999, 0, 32'h0,   0, 32'h804,      1, 0, 0, 32'h808,      1, 32'h88888888);

        repeat (2) @(posedge clk);
        #1;
        check("reset.imem_req", 32'(imem_req), 32'h0);
        check("reset.freeze", 32'(freeze), 32'h1);
        check("reset.flush_if", 32'(flush_if), 32'h0);
        check("reset.inst_valid", 32'(inst_valid), 32'h0);
        check("reset.inst", inst, 32'h0);
        check("reset.next_address", next_address, 32'h4);
        reset = 1'b1;

        foreach (tbl[i]) begin
            if (i == RST_IDX) begin
                // Reset lands mid-cycle while a ready with a parked redirect is on the inputs.
                pc = 32'h800; imem_ready = 1'b1; branch_taken = 1'b0; hazard_stall = 1'b0;
                #2;
                reset = 1'b0;
                #1;
                check("midreset.imem_req", 32'(imem_req), 32'h0);
                check("midreset.freeze", 32'(freeze), 32'h1);
                check("midreset.inst_valid", 32'(inst_valid), 32'h0);
                check("midreset.flush_if", 32'(flush_if), 32'h0);
                model_reset();
                @(posedge clk);
                #1;
                reset = 1'b1;
            end
`ifdef FETCH_PERF_EN
            if (i == 4) begin
                f0 = fetch_count;
                w0 = wait_count;
            end
`endif
            run_vec(i, tbl[i]);
`ifdef FETCH_PERF_EN
            if (i == 9) begin
                check("perf.fetch_delta", fetch_count - f0, 32'd2);
                check("perf.wait_delta", wait_count - w0, 32'd4);
            end
`endif
        end

        pc_reg = 32'hFFFFFFE0;
        for (int c = 0; c < 3000; c++) begin
            logic        r_rdy, r_br, r_stall;
            logic [31:0] r_data, r_baddr;
            r_rdy   = 1'($urandom_range(0, 1));
            r_br    = ($urandom_range(0, 99) < 15);
            r_stall = ($urandom_range(0, 99) < 25);
            r_data  = $urandom;
            r_baddr = $urandom & 32'hFFFFFFFC;
            imem_ready = r_rdy; imem_rdata = r_data; branch_taken = r_br;
            branch_addr = r_baddr; hazard_stall = r_stall; pc = pc_reg;
            model_eval(r_rdy, r_data, r_br, r_baddr, r_stall, pc_reg);
            @(negedge clk);
            check($sformatf("rnd%0d.imem_req", c), 32'(imem_req), 32'(e_req));
            check($sformatf("rnd%0d.freeze", c), 32'(freeze), 32'(e_freeze));
            check($sformatf("rnd%0d.flush_if", c), 32'(flush_if), 32'(e_flush));
            check($sformatf("rnd%0d.next_address", c), next_address, e_next);
            check($sformatf("rnd%0d.inst_valid", c), 32'(inst_valid), 32'(e_valid));
            check($sformatf("rnd%0d.inst", c), inst, e_inst);
            @(posedge clk);
            model_commit();
            if (!e_freeze) pc_reg = e_next;
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Drives the PC register's next_address and freeze inputs.
- Handshakes with instruction memory and buffers the fetched word for IF/ID.
- Resolves redirects from EXE. Redirects arriving mid-fetch are held pending and applied when the fetch completes.
- Holds the fetched instruction while the hazard unit stalls the pipeline.

Parameters:
- ADDR_W, 32, width of the PC, next_address and branch target.
- DATA_W, 32, instruction word width.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current PC register value; also used as the imem address.
- next_address  out  ADDR_W  next PC value, driven to the PC register.
- freeze  out  1  1 = PC register holds its value.
- imem_req  out  1  fetch request for address pc.
- imem_ready  in  1  memory completes the fetch this cycle; imem_rdata is valid.
- imem_rdata  in  DATA_W  fetched word.
- branch_taken  in  1  redirect request from EXE (single-cycle pulse).
- branch_addr  in  ADDR_W  redirect target.
- hazard_stall  in  1  downstream pipeline cannot accept an instruction.
- inst_valid  out  1  inst holds a correct-path instruction.
- inst  out  DATA_W  buffered instruction word.
- flush_if  out  1  redirect applied this cycle; IF/ID must discard its contents.

Behaviour:
- Reset (reset=0):
  - state=IDLE; inst_valid=0; inst=0; pend_valid=0; pend_addr=0.
  - imem_req=0; freeze=1.
- next_address defaults to pc+PC_STEP, truncated to ADDR_W; it wraps from 0xFFFFFFFC to 0x0.
- freeze=1 in every cycle not listed below as an advance or redirect.
- flush_if=1 exactly in redirect cycles.
- All outputs except next_address, freeze and flush_if are registered.
- IDLE:
  - imem_req=0.
  - Go to REQ when hazard_stall=0; otherwise stay in IDLE.
- REQ:
  - imem_req=1; request is held until imem_ready=1.
  - Without imem_ready, branch_taken=1 sets pend_valid=1 and pend_addr=branch_addr. A later branch overwrites the pending one.
  - Ready with branch_taken=1 is a redirect: next_address=branch_addr, freeze=0, inst_valid<=0, pend cleared, stay in REQ. branch_taken beats pend.
  - Ready with pend_valid=1 is a redirect: next_address=pend_addr, freeze=0, inst_valid<=0, pend cleared, stay in REQ.
  - Ready with hazard_stall=1: inst<=imem_rdata, inst_valid<=1, freeze=1, go to HOLD.
  - Otherwise, ready is an advance: inst<=imem_rdata, inst_valid<=1, freeze=0, next_address=pc+PC_STEP, stay in REQ. This gives back-to-back fetches, 1 instruction per cycle when imem_ready is held high.
  - In any REQ cycle without ready or redirect: inst_valid<=0.
- HOLD:
  - imem_req=0; inst and inst_valid are held.
  - branch_taken=1 is a redirect: next_address=branch_addr, freeze=0, inst_valid<=0, go to REQ.
  - Else hazard_stall=0 is an advance: freeze=0, next_address=pc+PC_STEP, go to REQ.
- Fetch latency: the first imem_req occurs the cycle after reset release (IDLE→REQ). inst_valid rises the cycle after imem_ready.
- Reset asserted mid-fetch: imem_req drops immediately and the in-flight data is dropped. After release, fetching restarts at pc.
- hazard_stall never aborts an issued request.
- Redirect while in IDLE: ignored. EXE is empty at that point.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs fetch_count and wait_count, both 32 bits, reset to 0, wrapping.
  - fetch_count increments on each advance.
  - wait_count increments on each REQ cycle with imem_ready=0.
- Undefined: both ports and both counters are absent. All other behaviour is identical.

Test Plan:
1. Reset release with pc=0, imem_ready tied 1, hazard_stall=0:
   - imem_req rises 1 cycle after release.
   - next_address=0x4 with freeze=0 on the first ready cycle.
   - inst_valid=1 every following cycle; inst tracks imem_rdata.
2. Slow memory, imem_ready asserted every 3rd cycle:
   - freeze=1 for 2 cycles, then freeze=0 for 1 cycle; inst_valid pulses 1 cycle per fetch.
   - With FETCH_PERF_EN: wait_count = 2×fetch_count.
3. branch_taken with branch_addr=0x100 during a REQ wait cycle (imem_ready=0), ready arrives 2 cycles later:
   - next_address=0x100, freeze=0, flush_if=1 on the ready cycle.
   - inst_valid stays 0.
4. hazard_stall=1 when ready arrives with imem_rdata=0xDEADBEEF:
   - Enter HOLD; inst=0xDEADBEEF with inst_valid=1 held for the stall duration; imem_req=0; freeze=1.
   - Stall drops: freeze=0, next_address=pc+4.
5. pc=0xFFFFFFFC, advance:
   - next_address=0x00000000.
6. reset pulsed low mid-REQ with pend_valid=1:
   - imem_req=0 and freeze=1 immediately; inst_valid=0.
   - Pending redirect lost: no flush_if after release.
